load_store_unit: RTL and testbench

//  Request/response front end for data_memory; sits between EX/MEM control and the memory array.

---
 rtl/load_store_unit.sv | 198 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Request/response front end for data_memory. Registers a single
//             load or store, validates it, drives one memory strobe cycle and
//             returns sign/zero-extended load data through a response
//             handshake.
//  Revision : 1.0  initial release
//
//  Build option:
//    LSU_MISALIGN_TRAP_EN  when defined, misaligned halfword/word accesses
//                          fault with no memory strobe. When undefined they
//                          are passed to data_memory unchanged.
//
//  Ports:
//    clock_i        clock, all state updates on rising edge
//    reset_i        synchronous active-high reset
//    req_valid_i    request present        req_ready_o  LSU idle, can accept
//    req_write_i    1 = store, 0 = load    req_funct3_i RISC-V funct3
//    req_addr_i     byte address           req_wdata_i  store data
//    resp_valid_o   response present       resp_ready_i consumer takes it
//    resp_rdata_o   extended load data (0 for stores and faults)
//    resp_fault_o   request rejected, no memory access performed
//    mem_read_o / mem_write_o / mem_funct3_o / mem_addr_o / mem_wdata_o
//                   strobe and data to data_memory (all 0 outside ACCESS)
//    mem_rdata_i    combinational read data from data_memory
// ============================================================================
module load_store_unit #(
   parameter int MEM_BYTES = 1024
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] resp_rdata_o,
   output logic        resp_fault_o,
   output logic        mem_read_o,
   output logic        mem_write_o,
   output logic [2:0]  mem_funct3_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_e;

   localparam logic [32:0] c_mem_limit = 33'(MEM_BYTES);

   state_e      state_q,  state_d;
   logic        write_q,  write_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q,   addr_d;
   logic [31:0] wdata_q,  wdata_d;
   logic [31:0] rdata_q,  rdata_d;
   logic        fault_q,  fault_d;

   // ---------------------------------------------------------------------
   // Legality check on the incoming request (evaluated before latching)
   // ---------------------------------------------------------------------
   logic        w_bad_funct3;
   logic [1:0]  w_size_m1;
   logic [32:0] w_last_byte;
   logic        w_out_of_range;
   logic        w_misaligned;
   logic        w_illegal;

   always_comb begin
      w_bad_funct3 = 1'b0;
      case (req_funct3_i)
         3'b000, 3'b001, 3'b010: w_bad_funct3 = 1'b0;
         3'b100, 3'b101:         w_bad_funct3 = req_write_i;   // no unsigned stores
         default:                w_bad_funct3 = 1'b1;
      endcase
   end

   // size-1 from funct3[1:0]: byte 0, half 1, word 3
   assign w_size_m1      = (req_funct3_i[1:0] == 2'b10) ? 2'd3 :
                           (req_funct3_i[1:0] == 2'b01) ? 2'd1 : 2'd0;
   // 33-bit sum so an address near 2^32 cannot wrap into range
   assign w_last_byte    = {1'b0, req_addr_i} + {31'd0, w_size_m1};
   assign w_out_of_range = (w_last_byte >= c_mem_limit);

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_misaligned   = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                           ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
   assign w_misaligned   = 1'b0;
`endif

   assign w_illegal = w_bad_funct3 | w_out_of_range | w_misaligned;

   // ---------------------------------------------------------------------
   // Load data extension; bits above the access size are discarded
   // ---------------------------------------------------------------------
   logic [31:0] w_ext;

   always_comb begin
      w_ext = 32'd0;
      case (funct3_q)
         3'b000:  w_ext = {{24{mem_rdata_i[7]}},  mem_rdata_i[7:0]};
         3'b001:  w_ext = {{16{mem_rdata_i[15]}}, mem_rdata_i[15:0]};
         3'b010:  w_ext = mem_rdata_i;
         3'b100:  w_ext = {24'd0, mem_rdata_i[7:0]};
         3'b101:  w_ext = {16'd0, mem_rdata_i[15:0]};
         default: w_ext = 32'd0;
      endcase
   end

   // ---------------------------------------------------------------------
   // Next-state and outputs
   // ---------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      funct3_d     = funct3_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      fault_d      = fault_q;
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      mem_funct3_o = 3'd0;
      mem_addr_o   = 32'd0;
      mem_wdata_o  = 32'd0;

      case (state_q)
         S_IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               write_d  = req_write_i;
               funct3_d = req_funct3_i;
               addr_d   = req_addr_i;
               wdata_d  = req_wdata_i;
               rdata_d  = 32'd0;
               fault_d  = w_illegal;
               // illegal requests skip the memory cycle entirely
               state_d  = w_illegal ? S_RESP : S_ACCESS;
            end
         end
         S_ACCESS: begin
            mem_read_o   = ~write_q;
            mem_write_o  = write_q;
            mem_funct3_o = {1'b0, funct3_q[1:0]};
            mem_addr_o   = addr_q;
            mem_wdata_o  = wdata_q;
            rdata_d      = write_q ? 32'd0 : w_ext;
            state_d      = S_RESP;
         end
         S_RESP: begin
            resp_valid_o = 1'b1;
            if (resp_ready_i) begin
               // clear so the response outputs idle at zero
               rdata_d = 32'd0;
               fault_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign resp_rdata_o = rdata_q;
   assign resp_fault_o = fault_q;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         write_q  <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         rdata_q  <= 32'd0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         write_q  <= write_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         fault_q  <= fault_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Purpose  : Self-checking bench for load_store_unit with a byte-array
//             model of data_memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

   logic        clock, reset;
   logic        req_valid, req_ready, req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_fault;
   logic [31:0] resp_rdata;
   logic        mem_read, mem_write;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;

   load_store_unit #(.MEM_BYTES(1024)) dut (
      .clock_i      (clock),
      .reset_i      (reset),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_write_i  (req_write),
      .req_funct3_i (req_funct3),
      .req_addr_i   (req_addr),
      .req_wdata_i  (req_wdata),
      .resp_valid_o (resp_valid),
      .resp_ready_i (resp_ready),
      .resp_rdata_o (resp_rdata),
      .resp_fault_o (resp_fault),
      .mem_read_o   (mem_read),
      .mem_write_o  (mem_write),
      .mem_funct3_o (mem_funct3),
      .mem_addr_o   (mem_addr),
      .mem_wdata_o  (mem_wdata),
      .mem_rdata_i  (mem_rdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- data_memory model (little-endian, unsigned reads) ----
   logic [7:0] mem [0:1023];

   function automatic logic [7:0] rd(input logic [31:0] a);
      return mem[a[9:0]];
   endfunction

   always_comb begin
      case (mem_funct3)
         3'b000:  mem_rdata = {24'd0, rd(mem_addr)};
         3'b001:  mem_rdata = {16'd0, rd(mem_addr + 32'd1), rd(mem_addr)};
         default: mem_rdata = {rd(mem_addr + 32'd3), rd(mem_addr + 32'd2),
                               rd(mem_addr + 32'd1), rd(mem_addr)};
      endcase
   end

   int          strobes = 0;
   logic [2:0]  last_f3;
   logic [31:0] last_addr;

   always @(posedge clock) begin
      if (mem_read || mem_write) begin
         strobes   = strobes + 1;
         last_f3   = mem_funct3;
         last_addr = mem_addr;
      end
      if (mem_write) begin
         mem[mem_addr[9:0]] <= mem_wdata[7:0];
         if (mem_funct3 != 3'b000)
            mem[(mem_addr[9:0] + 10'd1)] <= mem_wdata[15:8];
         if (mem_funct3 == 3'b010) begin
            mem[(mem_addr[9:0] + 10'd2)] <= mem_wdata[23:16];
            mem[(mem_addr[9:0] + 10'd3)] <= mem_wdata[31:24];
         end
      end
   end

   // ---------------- checking helpers -------------------------------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      string       name;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_fault;
      logic [2:0]  exp_mf3;
   } vec_t;

   vec_t vecs [16];

   // One full transaction: accept, wait for response, check, handshake.
   task automatic do_req(input vec_t v);
      int s0, cyc;
      req_write  = v.wr;
      req_funct3 = v.f3;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      req_valid  = 1'b1;
      chk({v.name, " req_ready"}, {31'd0, req_ready}, 32'd1);
      s0 = strobes;
      @(posedge clock); #1;
      req_valid = 1'b0;
      cyc = 1;
      while (!resp_valid && cyc < 10) begin
         @(posedge clock); #1;
         cyc++;
      end
      chk({v.name, " latency"}, cyc, v.exp_fault ? 32'd1 : 32'd2);
      chk({v.name, " rdata"}, resp_rdata, v.exp_rdata);
      chk({v.name, " fault"}, {31'd0, resp_fault}, {31'd0, v.exp_fault});
      chk({v.name, " strobes"}, strobes - s0, v.exp_fault ? 32'd0 : 32'd1);
      if (!v.exp_fault) begin
         chk({v.name, " mem_funct3"}, {29'd0, last_f3}, {29'd0, v.exp_mf3});
         chk({v.name, " mem_addr"}, last_addr, v.addr);
      end
      resp_ready = 1'b1;
      @(posedge clock); #1;
      resp_ready = 1'b0;
      chk({v.name, " resp_valid drop"}, {31'd0, resp_valid}, 32'd0);
   endtask

   initial begin
      int s0;
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

      //           name       wr    f3      addr          wdata          rdata          flt   mf3
      vecs[0]  = '{"SW8",     1'b1, 3'b010, 32'd8,        32'hDEADBEEF,  32'h0,         1'b0, 3'b010};
      vecs[1]  = '{"LW8",     1'b0, 3'b010, 32'd8,        32'h0,         32'hDEADBEEF,  1'b0, 3'b010};
      vecs[2]  = '{"SB3",     1'b1, 3'b000, 32'd3,        32'h12345680,  32'h0,         1'b0, 3'b000};
      vecs[3]  = '{"LB3",     1'b0, 3'b000, 32'd3,        32'h0,         32'hFFFFFF80,  1'b0, 3'b000};
      vecs[4]  = '{"LBU3",    1'b0, 3'b100, 32'd3,        32'h0,         32'h00000080,  1'b0, 3'b000};
      vecs[5]  = '{"SH4",     1'b1, 3'b001, 32'd4,        32'hFFFF8001,  32'h0,         1'b0, 3'b001};
      vecs[6]  = '{"LH4",     1'b0, 3'b001, 32'd4,        32'h0,         32'hFFFF8001,  1'b0, 3'b001};
      vecs[7]  = '{"LHU4",    1'b0, 3'b101, 32'd4,        32'h0,         32'h00008001,  1'b0, 3'b001};
      vecs[8]  = '{"LW1022",  1'b0, 3'b010, 32'd1022,     32'h0,         32'h0,         1'b1, 3'b010};
      vecs[9]  = '{"SB1023",  1'b1, 3'b000, 32'd1023,     32'h000000A5,  32'h0,         1'b0, 3'b000};
      vecs[10] = '{"LB1023",  1'b0, 3'b000, 32'd1023,     32'h0,         32'hFFFFFFA5,  1'b0, 3'b000};
      vecs[11] = '{"LW1020",  1'b0, 3'b010, 32'd1020,     32'h0,         32'hA5000000,  1'b0, 3'b010};
      vecs[12] = '{"F3_011",  1'b0, 3'b011, 32'd0,        32'h0,         32'h0,         1'b1, 3'b000};
      vecs[13] = '{"SBU",     1'b1, 3'b100, 32'd0,        32'h1,         32'h0,         1'b1, 3'b000};
      vecs[14] = '{"LH1023",  1'b0, 3'b001, 32'd1023,     32'h0,         32'h0,         1'b1, 3'b001};
      vecs[15] = '{"SWTOP",   1'b1, 3'b010, 32'hFFFFFFFF, 32'h0,         32'h0,         1'b1, 3'b010};

      req_valid = 0; req_write = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
      resp_ready = 0;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      // reset state
      chk("rst req_ready",  {31'd0, req_ready},  32'd1);
      chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst resp_rdata", resp_rdata,          32'd0);
      chk("rst resp_fault", {31'd0, resp_fault}, 32'd0);
      chk("rst mem_strobe", {30'd0, mem_read, mem_write}, 32'd0);
      chk("rst mem_addr",   mem_addr,            32'd0);

      for (int i = 0; i < 16; i++) do_req(vecs[i]);

      // misaligned word load at address 2; bytes 2..5 hold 00,80,01,80
      begin
         vec_t m;
`ifdef LSU_MISALIGN_TRAP_EN
         m = '{"LW2", 1'b0, 3'b010, 32'd2, 32'h0, 32'h0,        1'b1, 3'b010};
`else
         m = '{"LW2", 1'b0, 3'b010, 32'd2, 32'h0, 32'h80018000, 1'b0, 3'b010};
`endif
         do_req(m);
      end

      // backpressure: response held 5 cycles, new request stalls in RESP
      req_write = 0; req_funct3 = 3'b010; req_addr = 32'd8; req_valid = 1'b1;
      s0 = strobes;
      @(posedge clock); #1;
      @(posedge clock); #1;
      for (int c = 0; c < 5; c++) begin
         chk("bp resp_valid", {31'd0, resp_valid}, 32'd1);
         chk("bp rdata",      resp_rdata,          32'hDEADBEEF);
         chk("bp req_ready",  {31'd0, req_ready},  32'd0);
         @(posedge clock); #1;
      end
      chk("bp strobes", strobes - s0, 32'd1);
      // handshake with req_valid still high: request must not be taken yet
      resp_ready = 1'b1;
      #2 chk("bp req_ready at handshake", {31'd0, req_ready}, 32'd0);
      @(posedge clock); #1;
      resp_ready = 1'b0;
      chk("bp idle after", {30'd0, req_ready, resp_valid}, 32'd2);
      chk("bp no strobe yet", strobes - s0, 32'd1);
      @(posedge clock); #1;   // request accepted now
      req_valid = 1'b0;
      chk("bp second accept", {31'd0, mem_read}, 32'd1);
      @(posedge clock); #1;
      chk("bp second resp", resp_rdata, 32'hDEADBEEF);
      resp_ready = 1'b1;
      @(posedge clock); #1;
      resp_ready = 1'b0;

      // reset during ACCESS
      req_write = 0; req_funct3 = 3'b000; req_addr = 32'd3; req_valid = 1'b1;
      @(posedge clock); #1;
      req_valid = 1'b0;
      chk("rstacc in access", {31'd0, mem_read}, 32'd1);
      reset = 1'b1;
      s0 = strobes;
      @(posedge clock); #1;
      reset = 1'b0;
      chk("rstacc req_ready",  {31'd0, req_ready},  32'd1);
      chk("rstacc resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rstacc rdata",      resp_rdata,          32'd0);
      repeat (3) begin
         chk("rstacc quiet", {29'd0, resp_valid, mem_read, mem_write}, 32'd0);
         @(posedge clock); #1;
      end
      chk("rstacc strobes", strobes - s0, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
